// File: rtl/lc3_pkg.sv
// Shared types and device-space address map for the LC-3 memory interface.
// Included first; imported by lc3_mem_if and lc3_mmio_regs.
package lc3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  // Device space is the top 512 words: 0xFE00-0xFFFF.
  function automatic logic is_dev_addr(input logic [15:0] addr);
    return (addr[15:9] == 7'h7F);
  endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 keyboard/display device registers; accesses commit at the end of the DONE cycle.
// Read data is combinational from register state; no backpressure (disp_ack only re-arms DSR).
module lc3_mmio_regs
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  input  logic        kb_strobe_i,
  input  logic [7:0]  kb_data_i,
  output logic        disp_valid_o,
  output logic [7:0]  disp_data_o,
  input  logic        disp_ack_i,
  output logic        int_o
);

  logic       kb_rdy_q;
  logic       kb_ie_q;
  logic [7:0] kbdr_q;
  logic       dsr_rdy_q;
  logic [7:0] ddr_q;
  logic       disp_vld_q;

  logic kbsr_wr, kbdr_rd, ddr_wr;
  assign kbsr_wr = acc_i &  we_i & (addr_i == KBSR_ADDR);
  assign kbdr_rd = acc_i & ~we_i & (addr_i == KBDR_ADDR);
  assign ddr_wr  = acc_i &  we_i & (addr_i == DDR_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_rdy_q   <= 1'b0;
      kb_ie_q    <= 1'b0;
      kbdr_q     <= 8'h00;
      dsr_rdy_q  <= 1'b1;
      ddr_q      <= 8'h00;
      disp_vld_q <= 1'b0;
    end else begin
      disp_vld_q <= 1'b0;
      if (kbsr_wr) kb_ie_q <= wdata_i[14];
      // A new keystroke beats a concurrent KBDR read so the character is not lost.
      if (kb_strobe_i) begin
        kbdr_q   <= kb_data_i;
        kb_rdy_q <= 1'b1;
      end else if (kbdr_rd) begin
        kb_rdy_q <= 1'b0;
      end
      if (ddr_wr) begin
        ddr_q      <= wdata_i[7:0];
        disp_vld_q <= 1'b1;
        dsr_rdy_q  <= 1'b0;
      end else if (disp_ack_i) begin
        dsr_rdy_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata_o = 16'h0000;
    case (addr_i)
      KBSR_ADDR: rdata_o = {kb_rdy_q, kb_ie_q, 14'h0000};
      KBDR_ADDR: rdata_o = {8'h00, kbdr_q};
      DSR_ADDR:  rdata_o = {dsr_rdy_q, 15'h0000};
      default:   rdata_o = 16'h0000;
    endcase
  end

  assign disp_valid_o = disp_vld_q;
  assign disp_data_o  = ddr_q;
  assign int_o        = kb_rdy_q & kb_ie_q;

  logic unused_wdata;
  assign unused_wdata = ^{wdata_i[15], wdata_i[13:8]};

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 memory interface: WAIT_CYCLES wait states, one SRAM access cycle, R pulse (WAIT_CYCLES+2 cycles).
// mio_en ignored outside IDLE; optional device space under LC3_MMIO_EN.
module lc3_mem_if
  import lc3_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic        R,
  output logic [15:0] mdr_out,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        kb_strobe,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack,
  output logic        INT
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, wdata_q, mdr_q;
  logic        we_q;
  logic        dev_sel;
  logic [15:0] rd_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mio_en) begin
          state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      mdr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_out;
      if (state_q == IDLE && mio_en) begin
        addr_q  <= mar;
        wdata_q <= mdr_in;
        we_q    <= r_w;
      end
    end
  end

`ifdef LC3_MMIO_EN
  logic [15:0] dev_rdata;
  assign dev_sel = is_dev_addr(addr_q);

  lc3_mmio_regs u_mmio (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_i        (state_q == DONE),
    .we_i         (we_q),
    .addr_i       (addr_q),
    .wdata_i      (wdata_q),
    .rdata_o      (dev_rdata),
    .kb_strobe_i  (kb_strobe),
    .kb_data_i    (kb_data),
    .disp_valid_o (disp_valid),
    .disp_data_o  (disp_data),
    .disp_ack_i   (disp_ack),
    .int_o        (INT)
  );

  assign rd_data = dev_sel ? dev_rdata : mem_rdata;
`else
  assign dev_sel    = 1'b0;
  assign rd_data    = mem_rdata;
  assign disp_valid = 1'b0;
  assign disp_data  = 8'h00;
  assign INT        = 1'b0;

  logic unused_dev_inputs;
  assign unused_dev_inputs = ^{kb_strobe, kb_data, disp_ack};
`endif

  assign mem_en    = (state_q == ACCESS) & ~dev_sel;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // SRAM data arrives during DONE; show it live and keep it in mdr_q afterwards.
  assign R       = (state_q == DONE);
  assign mdr_out = (R && !we_q) ? rd_data : mdr_q;

endmodule

// File: tb/tb_lc3_mem_if.sv
// Directed bench for lc3_mem_if: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances with SRAM models.
module tb_lc3_mem_if;
  import lc3_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mio_en = 1'b0, mio_en0 = 1'b0, r_w = 1'b0;
  logic [15:0] mar = 16'h0, mdr_in = 16'h0;
  logic        kb_strobe = 1'b0, disp_ack = 1'b0;
  logic [7:0]  kb_data = 8'h00;

  logic        r2, mem_en2, mem_we2, disp_valid2, int2;
  logic [15:0] mdr_out2, mem_addr2, mem_wdata2, mem_rdata2;
  logic [7:0]  disp_data2;
  logic        r0, mem_en0, mem_we0, disp_valid0, int0;
  logic [15:0] mdr_out0, mem_addr0, mem_wdata0, mem_rdata0;
  logic [7:0]  disp_data0;

  lc3_mem_if #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .mio_en(mio_en), .r_w(r_w), .mar(mar), .mdr_in(mdr_in),
    .R(r2), .mdr_out(mdr_out2), .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .kb_strobe(kb_strobe), .kb_data(kb_data),
    .disp_valid(disp_valid2), .disp_data(disp_data2), .disp_ack(disp_ack), .INT(int2)
  );

  lc3_mem_if #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mio_en(mio_en0), .r_w(r_w), .mar(mar), .mdr_in(mdr_in),
    .R(r0), .mdr_out(mdr_out0), .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .kb_strobe(kb_strobe), .kb_data(kb_data),
    .disp_valid(disp_valid0), .disp_data(disp_data0), .disp_ack(disp_ack), .INT(int0)
  );

  logic [15:0] sram2 [0:65535];
  logic [15:0] sram0 [0:65535];

  always @(posedge clk) begin
    if (mem_en2) begin
      if (mem_we2) sram2[mem_addr2] <= mem_wdata2;
      mem_rdata2 <= sram2[mem_addr2];
    end
    if (mem_en0) begin
      if (mem_we0) sram0[mem_addr0] <= mem_wdata0;
      mem_rdata0 <= sram0[mem_addr0];
    end
  end

  int dv_cnt = 0;
  always @(posedge clk) if (disp_valid2) dv_cnt <= dv_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access; mio_en is held for a single edge and the request inputs are then
  // scrambled, so the DUT must work from its latched copies.
  task automatic run_acc(input bit sel0, input logic we, input logic [15:0] a,
                         input logic [15:0] d, output int c_mem, output int c_r,
                         output int n_r, output logic [15:0] rdv, output logic [15:0] ma,
                         output logic mw, output logic [15:0] after);
    c_mem = -1; c_r = -1; n_r = 0; rdv = 'x; ma = 'x; mw = 1'bx;
    @(negedge clk);
    if (sel0) mio_en0 = 1'b1; else mio_en = 1'b1;
    r_w = we; mar = a; mdr_in = d;
    @(posedge clk); #1;
    mio_en = 1'b0; mio_en0 = 1'b0; r_w = ~we; mar = ~a; mdr_in = ~d;
    for (int c = 1; c <= 8; c++) begin
      if ((sel0 ? mem_en0 : mem_en2) && c_mem < 0) begin
        c_mem = c;
        ma = sel0 ? mem_addr0 : mem_addr2;
        mw = sel0 ? mem_we0 : mem_we2;
      end
      if (sel0 ? r0 : r2) begin
        n_r++;
        if (c_r < 0) begin
          c_r = c;
          rdv = sel0 ? mdr_out0 : mdr_out2;
        end
      end
      @(posedge clk); #1;
    end
    after = sel0 ? mdr_out0 : mdr_out2;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          cmem;
    logic [15:0] mdr;
  } vec_t;

  vec_t vt [8];

  initial begin
    int cm, cr, nr, cnt_r, cnt_m, r_last;
    logic [15:0] rv, ma, aft;
    logic mw;

    vt[0] = '{1'b1, 16'h3000, 16'h1234, 3, 16'h0000};
    vt[1] = '{1'b0, 16'h3000, 16'h0000, 3, 16'h1234};
    vt[2] = '{1'b1, 16'h3001, 16'hABCD, 3, 16'h1234};
    vt[3] = '{1'b0, 16'h3001, 16'h0000, 3, 16'hABCD};
    vt[4] = '{1'b0, 16'h0100, 16'h0000, 3, 16'hCAFE};
    vt[5] = '{1'b0, 16'h0000, 16'h0000, 3, 16'h8001};
`ifdef LC3_MMIO_EN
    vt[6] = '{1'b1, 16'hFFFF, 16'h5A5A, -1, 16'h8001};
    vt[7] = '{1'b0, 16'hFFFF, 16'h0000, -1, 16'h0000};
`else
    vt[6] = '{1'b1, 16'hFFFF, 16'h5A5A, 3, 16'h8001};
    vt[7] = '{1'b0, 16'hFFFF, 16'h0000, 3, 16'h5A5A};
`endif
    sram2[16'h0100] = 16'hCAFE;
    sram2[16'h0000] = 16'h8001;

    repeat (3) @(posedge clk);
    #1;
    chk("reset R", {31'd0, r2}, 32'd0);
    chk("reset mem_en", {31'd0, mem_en2}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we2}, 32'd0);
    chk("reset mdr_out", {16'd0, mdr_out2}, 32'd0);
    chk("reset INT", {31'd0, int2}, 32'd0);
    chk("reset disp_valid", {31'd0, disp_valid2}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_acc(1'b0, vt[i].we, vt[i].addr, vt[i].wdata, cm, cr, nr, rv, ma, mw, aft);
      chk($sformatf("v%0d mem_en cycle", i), cm, vt[i].cmem);
      chk($sformatf("v%0d R cycle", i), cr, 32'd4);
      chk($sformatf("v%0d R pulses", i), nr, 32'd1);
      chk($sformatf("v%0d mdr_out at R", i), {16'd0, rv}, {16'd0, vt[i].mdr});
      chk($sformatf("v%0d mdr_out held", i), {16'd0, aft}, {16'd0, vt[i].mdr});
      if (vt[i].cmem > 0) begin
        chk($sformatf("v%0d mem_addr", i), {16'd0, ma}, {16'd0, vt[i].addr});
        chk($sformatf("v%0d mem_we", i), {31'd0, mw}, {31'd0, vt[i].we});
      end
    end

    // Reset asserted in WAIT aborts the access.
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b0; mar = 16'h3000;
    @(posedge clk); #1;
    mio_en = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    cnt_r = 0; cnt_m = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (r2) cnt_r++;
      if (mem_en2) cnt_m++;
      @(posedge clk);
    end
    #1;
    chk("rst mid R pulses", cnt_r, 32'd0);
    chk("rst mid mem_en", cnt_m, 32'd0);
    chk("rst mid mdr_out", {16'd0, mdr_out2}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_acc(1'b0, 1'b0, 16'h3001, 16'h0, cm, cr, nr, rv, ma, mw, aft);
    chk("post-rst mem_en cycle", cm, 32'd3);
    chk("post-rst R cycle", cr, 32'd4);
    chk("post-rst read", {16'd0, rv}, 32'h0000ABCD);

    // mio_en held high: second access accepted only after DONE.
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b0; mar = 16'h0100;
    @(posedge clk); #1;
    cnt_r = 0; r_last = -1;
    for (int c = 1; c <= 9; c++) begin
      if (r2) begin cnt_r++; r_last = c; end
      @(posedge clk); #1;
    end
    mio_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("held mio_en R pulses", cnt_r, 32'd2);
    chk("held mio_en 2nd R cycle", r_last, 32'd9);

    // Zero wait states.
    run_acc(1'b1, 1'b1, 16'h4000, 16'hBEEF, cm, cr, nr, rv, ma, mw, aft);
    chk("w0 wr mem_en cycle", cm, 32'd1);
    chk("w0 wr R cycle", cr, 32'd2);
    chk("w0 wr mem_addr", {16'd0, ma}, 32'h00004000);
    chk("w0 wr mem_we", {31'd0, mw}, 32'd1);
    chk("w0 sram", {16'd0, sram0[16'h4000]}, 32'h0000BEEF);
    run_acc(1'b1, 1'b0, 16'h4000, 16'h0, cm, cr, nr, rv, ma, mw, aft);
    chk("w0 rd R cycle", cr, 32'd2);
    chk("w0 rd R pulses", nr, 32'd1);
    chk("w0 rd data", {16'd0, rv}, 32'h0000BEEF);

    @(negedge clk); kb_strobe = 1'b1; kb_data = 8'h41;
    @(negedge clk); kb_strobe = 1'b0;
`ifdef LC3_MMIO_EN
    run_acc(1'b0, 1'b1, KBSR_ADDR, 16'h4000, cm, cr, nr, rv, ma, mw, aft);
    chk("kbsr wr no sram", cm, -1);
    chk("INT set", {31'd0, int2}, 32'd1);
    run_acc(1'b0, 1'b0, KBDR_ADDR, 16'h0, cm, cr, nr, rv, ma, mw, aft);
    chk("kbdr read", {16'd0, rv}, 32'h00000041);
    chk("INT cleared", {31'd0, int2}, 32'd0);
    run_acc(1'b0, 1'b0, KBSR_ADDR, 16'h0, cm, cr, nr, rv, ma, mw, aft);
    chk("kbsr read", {16'd0, rv}, 32'h00004000);
    run_acc(1'b0, 1'b1, DDR_ADDR, 16'h0058, cm, cr, nr, rv, ma, mw, aft);
    chk("ddr R cycle", cr, 32'd4);
    chk("disp_valid pulses", dv_cnt, 32'd1);
    chk("disp_data", {24'd0, disp_data2}, 32'h58);
    run_acc(1'b0, 1'b0, DSR_ADDR, 16'h0, cm, cr, nr, rv, ma, mw, aft);
    chk("dsr busy", {16'd0, rv}, 32'h0);
    @(negedge clk); disp_ack = 1'b1;
    @(negedge clk); disp_ack = 1'b0;
    run_acc(1'b0, 1'b0, DSR_ADDR, 16'h0, cm, cr, nr, rv, ma, mw, aft);
    chk("dsr ready", {16'd0, rv}, 32'h00008000);
`else
    #1;
    chk("no mmio INT", {31'd0, int2}, 32'd0);
    chk("no mmio disp_valid", dv_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
